// File: rtl/synth_pkg.sv
// Shared types for the synth voice path: allocator FSM encoding, voice-pick
// case codes, default note width and the voice-index width helper.
package synth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECIDE = 2'd1,
    ST_GAP    = 2'd2,
    ST_ASSIGN = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    PICK_NONE   = 3'd0,
    PICK_RETRIG = 3'd1,
    PICK_FREE   = 3'd2,
    PICK_REL    = 3'd3,
    PICK_STEAL  = 3'd4
  } pick_t;

  localparam int NOTE_W_DEF = 7;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/voice_pick.sv
// Combinational voice selector: same-note retrigger, lowest free voice,
// oldest released voice, oldest held voice. Age ties resolve to lowest index.
module voice_pick
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = NOTE_W_DEF,
  parameter int AGE_W      = 4,
  localparam int IW        = idx_w(NUM_VOICES)
) (
  input  logic [NUM_VOICES-1:0]        trig,
  input  logic [NUM_VOICES-1:0]        busy,
  input  logic [NUM_VOICES*NOTE_W-1:0] notes,
  input  logic [NUM_VOICES*AGE_W-1:0]  ages,
  input  logic [NOTE_W-1:0]            ev_note,
  output logic [IW-1:0]                pick_idx,
  output pick_t                        pick_code
);

  logic            hit_rt, hit_free, hit_rel, hit_st;
  logic [IW-1:0]   idx_rt, idx_free, idx_rel, idx_st;
  logic [AGE_W-1:0] best_rel, best_st;

  always_comb begin
    hit_rt   = 1'b0;
    hit_free = 1'b0;
    hit_rel  = 1'b0;
    hit_st   = 1'b0;
    idx_rt   = '0;
    idx_free = '0;
    idx_rel  = '0;
    idx_st   = '0;
    best_rel = '0;
    best_st  = '0;
    // Descending scan so the last hit recorded is the lowest index.
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (trig[i] && (notes[i*NOTE_W +: NOTE_W] == ev_note)) begin
        hit_rt = 1'b1;
        idx_rt = IW'(i);
      end
      if (!trig[i] && !busy[i]) begin
        hit_free = 1'b1;
        idx_free = IW'(i);
      end
    end
    // Ascending scan with strict compare keeps the lowest index on age ties.
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!trig[i] && busy[i] && (!hit_rel || (ages[i*AGE_W +: AGE_W] > best_rel))) begin
        hit_rel  = 1'b1;
        idx_rel  = IW'(i);
        best_rel = ages[i*AGE_W +: AGE_W];
      end
      if (trig[i] && (!hit_st || (ages[i*AGE_W +: AGE_W] > best_st))) begin
        hit_st  = 1'b1;
        idx_st  = IW'(i);
        best_st = ages[i*AGE_W +: AGE_W];
      end
    end
    pick_code = PICK_NONE;
    pick_idx  = '0;
    if (hit_rt) begin
      pick_code = PICK_RETRIG;
      pick_idx  = idx_rt;
    end else if (hit_free) begin
      pick_code = PICK_FREE;
      pick_idx  = idx_free;
    end else if (hit_rel) begin
      pick_code = PICK_REL;
      pick_idx  = idx_rel;
    end else if (hit_st) begin
      pick_code = PICK_STEAL;
      pick_idx  = idx_st;
    end
  end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator feeding a bank of adsr envelopes.
// Define VOICE_ALLOC_STEAL_EN to steal the oldest held voice instead of dropping.
module voice_alloc
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = NOTE_W_DEF,
  parameter int AGE_W      = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [NOTE_W-1:0]            ev_note,
  input  logic [NUM_VOICES-1:0]        voice_busy,
  output logic [NUM_VOICES-1:0]        voice_trig,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic                         steal,
  output logic                         dropped,
  output state_t                       dbg_state
);

  localparam int IW = idx_w(NUM_VOICES);
  localparam int GW = $clog2(GAP_CYCLES + 1);
`ifdef VOICE_ALLOC_STEAL_EN
  localparam bit STEAL_EN = 1'b1;
`else
  localparam bit STEAL_EN = 1'b0;
`endif

  state_t                       state, state_nxt;
  logic                         rdy_en;
  logic                         ev_on_q;
  logic [NOTE_W-1:0]            ev_note_q;
  logic [NUM_VOICES-1:0]        trig_q;
  logic [NUM_VOICES*NOTE_W-1:0] note_q;
  logic [AGE_W-1:0]             age_q [NUM_VOICES];
  logic [NUM_VOICES*AGE_W-1:0]  ages_flat;
  logic [GW-1:0]                gap_cnt;
  logic [IW-1:0]                pend_idx;
  logic                         steal_q, dropped_q;
  logic [IW-1:0]                pick_idx;
  pick_t                        pick_code;
  logic                         take_gap, assign_ok;

  always_comb begin
    ages_flat = '0;
    for (int i = 0; i < NUM_VOICES; i++) ages_flat[i*AGE_W +: AGE_W] = age_q[i];
  end

  voice_pick #(
    .NUM_VOICES(NUM_VOICES),
    .NOTE_W    (NOTE_W),
    .AGE_W     (AGE_W)
  ) u_pick (
    .trig     (trig_q),
    .busy     (voice_busy),
    .notes    (note_q),
    .ages     (ages_flat),
    .ev_note  (ev_note_q),
    .pick_idx (pick_idx),
    .pick_code(pick_code)
  );

  assign take_gap  = ev_on_q && ((pick_code == PICK_RETRIG) ||
                                 (STEAL_EN && (pick_code == PICK_STEAL)));
  assign assign_ok = ev_on_q && ((pick_code == PICK_RETRIG) || (pick_code == PICK_FREE) ||
                                 (pick_code == PICK_REL) ||
                                 (STEAL_EN && (pick_code == PICK_STEAL)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (ev_valid && ev_ready) state_nxt = ST_DECIDE;
      ST_DECIDE: state_nxt = take_gap ? ST_GAP : ST_IDLE;
      ST_GAP:    if (gap_cnt <= GW'(1)) state_nxt = ST_ASSIGN;
      ST_ASSIGN: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs. Handshake: an event transfers on a rising edge where ev_valid and
  // ev_ready are both high; ev_ready is high only in IDLE after reset release.
  always_comb begin
    ev_ready   = rdy_en && (state == ST_IDLE);
    dbg_state  = state;
    voice_trig = trig_q;
    voice_note = note_q;
    steal      = STEAL_EN ? steal_q : 1'b0;
    dropped    = STEAL_EN ? 1'b0 : dropped_q;
  end

  // Datapath: event latch, voice trig/note, ages, gap counter, pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en    <= 1'b0;
      ev_on_q   <= 1'b0;
      ev_note_q <= '0;
      trig_q    <= '0;
      note_q    <= '0;
      gap_cnt   <= '0;
      pend_idx  <= '0;
      steal_q   <= 1'b0;
      dropped_q <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= '0;
    end else begin
      rdy_en    <= 1'b1;
      steal_q   <= 1'b0;
      dropped_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ev_valid && ev_ready) begin
            ev_on_q   <= ev_on;
            ev_note_q <= ev_note;
          end
        end
        ST_DECIDE: begin
          if (!ev_on_q) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (trig_q[i] && (note_q[i*NOTE_W +: NOTE_W] == ev_note_q)) trig_q[i] <= 1'b0;
            end
          end else if (assign_ok) begin
            note_q[pick_idx*NOTE_W +: NOTE_W] <= ev_note_q;
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (i == int'(pick_idx))  age_q[i] <= '0;
              else if (age_q[i] != '1)  age_q[i] <= age_q[i] + 1'b1;
            end
            if (take_gap) begin
              trig_q[pick_idx] <= 1'b0;
              gap_cnt          <= GW'(GAP_CYCLES);
              pend_idx         <= pick_idx;
              steal_q          <= (pick_code == PICK_STEAL);
            end else begin
              trig_q[pick_idx] <= 1'b1;
            end
          end else begin
            dropped_q <= 1'b1;
          end
        end
        ST_GAP:    gap_cnt <= gap_cnt - 1'b1;
        ST_ASSIGN: trig_q[pend_idx] <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc (4 voices, 7-bit notes, gap of 4 cycles).
module tb_voice_alloc;
  import synth_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic        ev_on = 1'b0;
  logic [6:0]  ev_note = '0;
  logic [3:0]  voice_busy = '0;
  logic [3:0]  voice_trig;
  logic [27:0] voice_note;
  logic        steal;
  logic        dropped;
  state_t      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  voice_alloc #(
    .NUM_VOICES(4),
    .NOTE_W    (7),
    .AGE_W     (4),
    .GAP_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_on     (ev_on),
    .ev_note   (ev_note),
    .voice_busy(voice_busy),
    .voice_trig(voice_trig),
    .voice_note(voice_note),
    .steal     (steal),
    .dropped   (dropped),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [6:0] vn(input int i);
    return voice_note[i*7 +: 7];
  endfunction

  task automatic apply_reset();
    ev_valid   = 1'b0;
    voice_busy = '0;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Driver: wait (bounded) for ready, then present one event for one edge.
  task automatic send_event(input logic on, input logic [6:0] note);
    int waited;
    waited = 0;
    while (!ev_ready && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    n_checks++;
    if (ev_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: ev_ready=%0b required 1 (note %0d)", ev_ready, note);
    end
    ev_valid = 1'b1;
    ev_on    = on;
    ev_note  = note;
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (ev_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b required 0", ev_ready); end
    n_checks++;
    if (voice_trig !== 4'b0000) begin n_fail++; $display("FAIL reset_trig: got %b required 0000", voice_trig); end
    n_checks++;
    if (voice_note !== 28'd0) begin n_fail++; $display("FAIL reset_note: got %h required 0", voice_note); end
    n_checks++;
    if ({steal, dropped} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b required 00", {steal, dropped}); end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ev_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_pre_clk: got %0b required 0", ev_ready); end
    @(posedge clk);
    #1;
    n_checks++;
    if (ev_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_post: got %0b required 1", ev_ready); end
  endtask

  task automatic test_note_on_free();
    apply_reset();
    send_event(1'b1, 7'd60);
    n_checks++;
    if (voice_trig !== 4'b0000) begin n_fail++; $display("FAIL on_free_early: trig=%b required 0000", voice_trig); end
    @(posedge clk);
    #1;
    n_checks++;
    if (voice_trig !== 4'b0001) begin n_fail++; $display("FAIL on_free_trig: trig=%b required 0001", voice_trig); end
    n_checks++;
    if (vn(0) !== 7'd60) begin n_fail++; $display("FAIL on_free_note: got %0d required 60", vn(0)); end
    n_checks++;
    if (steal !== 1'b0) begin n_fail++; $display("FAIL on_free_steal: got %0b required 0", steal); end
    n_checks++;
    if (ev_ready !== 1'b1) begin n_fail++; $display("FAIL on_free_ready: got %0b required 1", ev_ready); end
  endtask

  task automatic test_note_off();
    apply_reset();
    send_event(1'b1, 7'd60);
    send_event(1'b1, 7'd62);
    send_event(1'b1, 7'd64);
    send_event(1'b0, 7'd62);
    @(posedge clk);
    #1;
    n_checks++;
    if (voice_trig !== 4'b0101) begin n_fail++; $display("FAIL note_off_trig: trig=%b required 0101", voice_trig); end
    n_checks++;
    if (voice_note !== {7'd0, 7'd64, 7'd62, 7'd60}) begin
      n_fail++; $display("FAIL note_off_notes: got %h required %h", voice_note, {7'd0, 7'd64, 7'd62, 7'd60});
    end
    send_event(1'b0, 7'd99);
    @(posedge clk);
    #1;
    n_checks++;
    if (voice_trig !== 4'b0101) begin n_fail++; $display("FAIL note_off_nomatch: trig=%b required 0101", voice_trig); end
  endtask

  task automatic test_retrigger();
    int  lowc;
    bit  others, saw_steal;
    apply_reset();
    send_event(1'b1, 7'd60);
    send_event(1'b1, 7'd60);
    lowc = 0;
    others = 1'b0;
    saw_steal = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (voice_trig[3:1] !== 3'b000) others = 1'b1;
      if (steal === 1'b1) saw_steal = 1'b1;
      if (c == 0) begin
        n_checks++;
        if (ev_ready !== 1'b0) begin n_fail++; $display("FAIL retrig_ready_gap: got %0b required 0", ev_ready); end
      end
      if (voice_trig[0] === 1'b1) break;
      lowc++;
    end
    n_checks++;
    if (lowc != 5) begin n_fail++; $display("FAIL retrig_low_cycles: got %0d required 5", lowc); end
    n_checks++;
    if (voice_trig !== 4'b0001) begin n_fail++; $display("FAIL retrig_trig: trig=%b required 0001", voice_trig); end
    n_checks++;
    if (others !== 1'b0) begin n_fail++; $display("FAIL retrig_other_voice: used=%0b required 0", others); end
    n_checks++;
    if (vn(0) !== 7'd60) begin n_fail++; $display("FAIL retrig_note: got %0d required 60", vn(0)); end
    n_checks++;
    if (saw_steal !== 1'b0) begin n_fail++; $display("FAIL retrig_steal: got %0b required 0", saw_steal); end
  endtask

  task automatic test_all_held();
    int lowc;
    apply_reset();
    send_event(1'b1, 7'd60);
    send_event(1'b1, 7'd61);
    send_event(1'b1, 7'd62);
    send_event(1'b1, 7'd63);
    send_event(1'b1, 7'd65);
    @(posedge clk);
    #1;
`ifdef VOICE_ALLOC_STEAL_EN
    n_checks++;
    if (steal !== 1'b1) begin n_fail++; $display("FAIL steal_pulse: got %0b required 1", steal); end
    n_checks++;
    if (voice_trig !== 4'b1110) begin n_fail++; $display("FAIL steal_trig_low: trig=%b required 1110", voice_trig); end
    @(posedge clk);
    #1;
    n_checks++;
    if (steal !== 1'b0) begin n_fail++; $display("FAIL steal_one_cycle: got %0b required 0", steal); end
    lowc = 2;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (voice_trig[0] === 1'b1) break;
      lowc++;
    end
    n_checks++;
    if (lowc != 5) begin n_fail++; $display("FAIL steal_low_cycles: got %0d required 5", lowc); end
    n_checks++;
    if (voice_trig !== 4'b1111) begin n_fail++; $display("FAIL steal_trig: trig=%b required 1111", voice_trig); end
    n_checks++;
    if (voice_note !== {7'd63, 7'd62, 7'd61, 7'd65}) begin
      n_fail++; $display("FAIL steal_notes: got %h required %h", voice_note, {7'd63, 7'd62, 7'd61, 7'd65});
    end
`else
    lowc = 0;
    n_checks++;
    if (dropped !== 1'b1) begin n_fail++; $display("FAIL drop_pulse: got %0b required 1", dropped); end
    n_checks++;
    if (steal !== 1'b0) begin n_fail++; $display("FAIL drop_steal: got %0b required 0", steal); end
    n_checks++;
    if (voice_trig !== 4'b1111) begin n_fail++; $display("FAIL drop_trig: trig=%b required 1111", voice_trig); end
    n_checks++;
    if (voice_note !== {7'd63, 7'd62, 7'd61, 7'd60}) begin
      n_fail++; $display("FAIL drop_notes: got %h required %h", voice_note, {7'd63, 7'd62, 7'd61, 7'd60});
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (dropped !== 1'b0) begin n_fail++; $display("FAIL drop_one_cycle: got %0b required 0", dropped); end
    n_checks++;
    if (ev_ready !== 1'b1 || lowc != 0) begin n_fail++; $display("FAIL drop_ready: got %0b required 1", ev_ready); end
`endif
  endtask

  task automatic test_released();
    // Voice 3 never used, voices 0/2 released but still sounding.
    apply_reset();
    send_event(1'b1, 7'd60);
    send_event(1'b1, 7'd61);
    send_event(1'b1, 7'd62);
    send_event(1'b0, 7'd62);
    send_event(1'b0, 7'd60);
    voice_busy = 4'b0101;
    send_event(1'b1, 7'd70);
    @(posedge clk);
    #1;
    n_checks++;
    if (voice_trig !== 4'b1010) begin n_fail++; $display("FAIL rel_free_trig: trig=%b required 1010", voice_trig); end
    n_checks++;
    if (voice_note !== {7'd70, 7'd62, 7'd61, 7'd60}) begin
      n_fail++; $display("FAIL rel_free_notes: got %h required %h", voice_note, {7'd70, 7'd62, 7'd61, 7'd60});
    end
    // Retriggers refresh voices 0/1 so voice 2 ends up oldest (ages 1,0,3,2).
    apply_reset();
    send_event(1'b1, 7'd60);
    send_event(1'b1, 7'd61);
    send_event(1'b1, 7'd62);
    send_event(1'b1, 7'd63);
    send_event(1'b1, 7'd60);
    send_event(1'b1, 7'd61);
    send_event(1'b0, 7'd62);
    send_event(1'b0, 7'd60);
    send_event(1'b0, 7'd61);
    send_event(1'b0, 7'd63);
    voice_busy = 4'b1111;
    send_event(1'b1, 7'd70);
    @(posedge clk);
    #1;
    n_checks++;
    if (voice_trig !== 4'b0100) begin n_fail++; $display("FAIL rel_oldest_trig: trig=%b required 0100", voice_trig); end
    n_checks++;
    if (vn(2) !== 7'd70) begin n_fail++; $display("FAIL rel_oldest_note: got %0d required 70", vn(2)); end
    n_checks++;
    if ({steal, dropped} !== 2'b00) begin n_fail++; $display("FAIL rel_oldest_pulses: got %b required 00", {steal, dropped}); end
    voice_busy = '0;
  endtask

  task automatic test_reset_mid_gap();
    bit rose;
    apply_reset();
    send_event(1'b1, 7'd60);
    send_event(1'b1, 7'd60);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (voice_trig !== 4'b0000 || voice_note !== 28'd0) begin
      n_fail++; $display("FAIL midgap_clear: trig=%b note=%h required 0000/0", voice_trig, voice_note);
    end
    n_checks++;
    if (ev_ready !== 1'b0) begin n_fail++; $display("FAIL midgap_ready: got %0b required 0", ev_ready); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    rose = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (voice_trig !== 4'b0000) rose = 1'b1;
    end
    n_checks++;
    if (rose !== 1'b0) begin n_fail++; $display("FAIL midgap_lost: trig rose=%0b required 0", rose); end
    n_checks++;
    if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL midgap_state: got %0d required %0d", dbg_state, ST_IDLE); end
  endtask

  initial begin
    test_reset();
    test_note_on_free();
    test_note_off();
    test_retrigger();
    test_all_held();
    test_released();
    test_reset_mid_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
